// File: rtl/program_memory.sv
// ---------------------------------------------------------------------------
// program_memory
// 32 x 8-bit program store shared between a byte-stream loader and a core.
// A loader fills memory from address 0 after load_start; when the load ends
// (load_last or the final address) the block either starts the core (RUN)
// or parks in LOADED until run_req, depending on AUTO_START. In RUN the core
// may write memory; reads are combinational in every state.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   mem_addr             core address for fetch/load/store
//   mem_write            core write strobe (honoured only in RUN)
//   mem_write_data       core store data
//   mem_read_data        combinational mem[mem_addr]
//   start_execution      core run enable, high only in RUN
//   load_start           begin (or restart) a load at address 0
//   load_valid/data/last loader byte stream
//   load_ready           byte accepted this cycle when load_valid is high
//   run_req              LOADED -> RUN request
//   load_count           bytes written by the current/last load (0..32)
//   load_busy            high while loading
// ---------------------------------------------------------------------------
module program_memory #(
    parameter bit AUTO_START = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] mem_addr,
    input  logic       mem_write,
    input  logic [7:0] mem_write_data,
    output logic [7:0] mem_read_data,
    output logic       start_execution,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    input  logic       run_req,
    output logic [5:0] load_count,
    output logic       load_busy
);

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADING,
        S_LOADED,
        S_RUN
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_ptr;
    logic [CW-1:0]   r_load_count;
    logic            r_start;
    logic            r_load_ready;
    logic            r_load_busy;
    logic            w_accept;
    logic            w_ptr_last;

    // A restart request outranks a byte arriving in the same cycle.
    assign w_accept   = load_valid && r_load_ready && !load_start;
    assign w_ptr_last = (r_ptr == AW'(DEPTH - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start) w_next = S_LOADING;
            end
            S_LOADING: begin
                if (load_start) begin
                    w_next = S_LOADING;
                end else if (w_accept && (load_last || w_ptr_last)) begin
                    w_next = AUTO_START ? S_RUN : S_LOADED;
                end
            end
            S_LOADED: begin
                if (load_start)   w_next = S_LOADING;
                else if (run_req) w_next = S_RUN;
            end
            S_RUN: begin
                if (load_start) w_next = S_LOADING;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Registered state decodes, load pointer/count and memory writes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_start      <= 1'b0;
            r_load_ready <= 1'b0;
            r_load_busy  <= 1'b0;
            r_ptr        <= '0;
            r_load_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_start      <= (w_next == S_RUN);
            r_load_ready <= (w_next == S_LOADING);
            r_load_busy  <= (w_next == S_LOADING);

            if (load_start) begin
                r_ptr        <= '0;
                r_load_count <= '0;
            end else if (w_accept) begin
                r_mem[r_ptr] <= load_data;
                r_ptr        <= r_ptr + AW'(1);
                r_load_count <= r_load_count + CW'(1);
            end

            // Loader and core writes never overlap: they live in different states.
            if ((r_state == S_RUN) && mem_write) begin
                r_mem[mem_addr] <= mem_write_data;
            end
        end
    end

    assign mem_read_data   = r_mem[mem_addr];
    assign start_execution = r_start;
    assign load_ready      = r_load_ready;
    assign load_busy       = r_load_busy;
    assign load_count      = r_load_count;

endmodule

// File: tb/tb_program_memory.sv
// ---------------------------------------------------------------------------
// tb_program_memory
// Scoreboard bench: stimulus pushes expected values into a queue; a monitor
// pops and compares each entry on the falling edge. Two instances share all
// inputs: dut (AUTO_START=1) and dut0 (AUTO_START=0).
// ---------------------------------------------------------------------------
module tb_program_memory;

    logic       clock;
    logic       reset;
    logic [4:0] mem_addr;
    logic       mem_write;
    logic [7:0] mem_write_data;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       run_req;

    logic [7:0] mem_read_data,   mem_read_data0;
    logic       start_execution, start_execution0;
    logic       load_ready,      load_ready0;
    logic [5:0] load_count,      load_count0;
    logic       load_busy,       load_busy0;

    program_memory #(.AUTO_START(1'b1)) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_addr        (mem_addr),
        .mem_write       (mem_write),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .start_execution (start_execution),
        .load_start      (load_start),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .load_last       (load_last),
        .load_ready      (load_ready),
        .run_req         (run_req),
        .load_count      (load_count),
        .load_busy       (load_busy)
    );

    program_memory #(.AUTO_START(1'b0)) dut0 (
        .clock           (clock),
        .reset           (reset),
        .mem_addr        (mem_addr),
        .mem_write       (mem_write),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data0),
        .start_execution (start_execution0),
        .load_start      (load_start),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .load_last       (load_last),
        .load_ready      (load_ready0),
        .run_req         (run_req),
        .load_count      (load_count0),
        .load_busy       (load_busy0)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef enum int {F_START, F_READY, F_BUSY, F_COUNT, F_RD,
                      F_START0, F_COUNT0, F_READY0} field_e;
    typedef struct {
        string  name;
        field_e field;
        int     exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic expect_val(input field_e f, input int e, input string n);
        exp_t x;
        x.name  = n;
        x.field = f;
        x.exp   = e;
        q.push_back(x);
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clock);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.field)
                    F_START:  act = int'(start_execution);
                    F_READY:  act = int'(load_ready);
                    F_BUSY:   act = int'(load_busy);
                    F_COUNT:  act = int'(load_count);
                    F_RD:     act = int'(mem_read_data);
                    F_START0: act = int'(start_execution0);
                    F_COUNT0: act = int'(load_count0);
                    F_READY0: act = int'(load_ready0);
                    default:  act = -1;
                endcase
                n_checks++;
                if (act != e.exp) begin
                    n_errors++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic check_mem(input logic [4:0] a, input int e, input string n);
        mem_addr = a;
        expect_val(F_RD, e, n);
        tick();
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        mem_addr       = '0;
        mem_write      = 1'b0;
        mem_write_data = '0;
        load_start     = 1'b0;
        load_valid     = 1'b0;
        load_data      = '0;
        load_last      = 1'b0;
        run_req        = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        expect_val(F_START, 0, "rst_start");
        expect_val(F_READY, 0, "rst_ready");
        expect_val(F_BUSY,  0, "rst_busy");
        expect_val(F_COUNT, 0, "rst_count");
        check_mem(5'd0,  8'h00, "rst_mem0");
        check_mem(5'd31, 8'h00, "rst_mem31");

        // Short load with load_last, auto start
        pulse_load_start();
        expect_val(F_READY, 1, "ld_ready");
        expect_val(F_BUSY,  1, "ld_busy");
        expect_val(F_COUNT, 0, "ld_count0");
        send_byte(8'h20, 1'b0);
        send_byte(8'h28, 1'b0);
        send_byte(8'hC9, 1'b1);
        expect_val(F_START,  1, "ld3_start");
        expect_val(F_COUNT,  3, "ld3_count");
        expect_val(F_READY,  0, "ld3_ready");
        expect_val(F_START0, 0, "ld3_start_noauto");
        check_mem(5'd0, 8'h20, "ld3_mem0");
        check_mem(5'd1, 8'h28, "ld3_mem1");
        check_mem(5'd2, 8'hC9, "ld3_mem2");

        // Core write in RUN: old data same cycle, new data next cycle
        mem_addr       = 5'd5;
        mem_write      = 1'b1;
        mem_write_data = 8'hA5;
        expect_val(F_RD, 8'h00, "wr_same_cycle");
        tick();
        mem_write = 1'b0;
        expect_val(F_RD, 8'hA5, "wr_next_cycle");
        tick();

        // Core write while LOADING is ignored
        pulse_load_start();
        mem_addr       = 5'd5;
        mem_write      = 1'b1;
        mem_write_data = 8'h3C;
        tick();
        mem_write = 1'b0;
        expect_val(F_RD,    8'hA5, "wr_loading_ignored");
        expect_val(F_COUNT, 0,     "restart_count");
        tick();

        // Full 32-byte load without load_last
        for (int i = 0; i < 31; i++) begin
            send_byte(8'(i), 1'b0);
        end
        expect_val(F_COUNT, 31, "ld31_count");
        expect_val(F_READY, 1,  "ld31_ready");
        send_byte(8'h1F, 1'b0);
        expect_val(F_COUNT,  32, "ld32_count");
        expect_val(F_READY,  0,  "ld32_ready");
        expect_val(F_START,  1,  "ld32_start");
        expect_val(F_COUNT0, 32, "ld32_count_noauto");
        expect_val(F_READY0, 0,  "ld32_ready_noauto");
        send_byte(8'hEE, 1'b0);
        expect_val(F_COUNT, 32, "ld33_not_accepted");
        check_mem(5'd31, 8'h1F, "ld32_mem31");
        check_mem(5'd0,  8'h00, "ld32_mem0");
        check_mem(5'd5,  8'h05, "ld32_mem5");

        // AUTO_START=0 waits in LOADED for run_req
        expect_val(F_START0, 0, "loaded_wait0");
        tick();
        expect_val(F_START0, 0, "loaded_wait1");
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        expect_val(F_START0, 1, "run_req_start");
        expect_val(F_START,  1, "run_req_auto_unaffected");
        tick();

        // Restart from RUN with a coinciding byte: byte dropped
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h77;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        expect_val(F_START, 0, "rs_start");
        expect_val(F_COUNT, 0, "rs_count");
        expect_val(F_READY, 1, "rs_ready");
        check_mem(5'd0, 8'h00, "rs_byte_dropped");
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        expect_val(F_COUNT, 2, "rs_count2");
        expect_val(F_START, 1, "rs_start2");
        check_mem(5'd0, 8'h11, "rs_mem0");
        check_mem(5'd1, 8'h22, "rs_mem1");
        check_mem(5'd2, 8'h02, "rs_mem2_kept");

        // Reset in the middle of a load
        pulse_load_start();
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hA3;
        tick();
        reset      = 1'b0;
        load_valid = 1'b0;
        expect_val(F_START, 0, "mr_start");
        expect_val(F_READY, 0, "mr_ready");
        expect_val(F_BUSY,  0, "mr_busy");
        expect_val(F_COUNT, 0, "mr_count");
        check_mem(5'd0,  8'h00, "mr_mem0");
        check_mem(5'd1,  8'h00, "mr_mem1");
        check_mem(5'd31, 8'h00, "mr_mem31");

        tick();
        tick();
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 Parameter: AUTO_START, default 1, meaning: 1 = enter RUN automatically when a load completes, 0 = wait in LOADED for run_req.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 mem_addr  input  5  core address (fetch, LOAD, STORE).
REQ-006 mem_write  input  1  core write strobe.
REQ-007 mem_write_data  input  8  core store data.
REQ-008 mem_read_data  output  8  combinational read of mem[mem_addr].
REQ-009 start_execution  output  1  core run enable; high only in RUN.
REQ-010 load_start  input  1  pulse; begin a program load at address 0.
REQ-011 load_valid  input  1  loader byte valid.
REQ-012 load_data  input  8  loader byte.
REQ-013 load_last  input  1  qualifies the final byte of a load.
REQ-014 load_ready  output  1  block accepts a loader byte; high only in LOADING.
REQ-015 run_req  input  1  LOADED -> RUN request (used when AUTO_START=0).
REQ-016 load_count  output  6  bytes written by the current/last load, 0..32.
REQ-017 load_busy  output  1  high in LOADING.

Function
REQ-018 Storage SHALL be 32 x 8-bit; addresses wrap never (5-bit address covers all entries).
REQ-019 FSM states SHALL be IDLE, LOADING, LOADED, RUN.
REQ-020 IDLE: load_start -> LOADING; all other inputs ignored.
REQ-021 LOADING entry SHALL clear the write pointer and load_count to 0 on the next edge.
REQ-022 Byte accept = load_valid && load_ready; on accept write load_data to mem[ptr], ptr+1, load_count+1.
REQ-023 Accept with load_last=1, or accept at ptr=31, SHALL end the load: -> RUN if AUTO_START=1, else -> LOADED.
REQ-024 Load of exactly 32 bytes SHALL give load_count=32 and a state exit; no byte is written beyond address 31.
REQ-025 LOADED: run_req -> RUN; load_start -> LOADING (restart).
REQ-026 RUN: start_execution=1; core writes honoured: mem_write=1 writes mem_write_data to mem[mem_addr] at the edge.
REQ-027 Core writes in any state other than RUN SHALL be ignored.
REQ-028 mem_read_data SHALL be mem[mem_addr] combinationally in all states; same-cycle read of a write address returns old data, new data from the next cycle.
REQ-029 load_start in LOADING or RUN SHALL restart: -> LOADING, ptr=0, load_count=0, start_execution low on the next edge; bytes already in memory are kept until overwritten.
REQ-030 load_start coinciding with a byte accept SHALL take priority; the byte is dropped.
REQ-031 load_ready and load_busy SHALL be registered state decodes (high exactly while in LOADING).
REQ-032 load_count SHALL hold its final value after the load until the next load_start.

Reset
REQ-033 On reset: state IDLE, ptr 0, load_count 0, start_execution 0, load_ready 0, load_busy 0, all 32 memory entries 0.
REQ-034 Reset mid-load or mid-run SHALL abort with the full reset values above on the next edge; reset overrides all inputs.

Verification
REQ-035 Reset, load_start, bytes 0x20,0x28,0xC9 (last on 3rd), AUTO_START=1 -> mem[0..2]=0x20,0x28,0xC9, load_count=3, start_execution=1 one cycle after last accept.
REQ-036 Load 32 bytes 0x00..0x1F with load_last never set -> exit after address 31, load_count=32, 33rd valid byte not accepted (load_ready=0).
REQ-037 RUN, mem_addr=5, mem_write=1, data 0xA5 -> mem_read_data at addr 5 = old value same cycle, 0xA5 next cycle; same write during LOADING -> no change.
REQ-038 AUTO_START=0, complete load -> state LOADED, start_execution=0 until run_req pulse, then 1 next cycle.
REQ-039 load_start during RUN with load_valid high -> start_execution 0, load_count 0, byte dropped; following bytes written from address 0.
REQ-040 Reset asserted after 2 of 4 bytes loaded -> all outputs reset values, mem[0..1]=0x00.
